button_debounce: RTL and testbench
==================================

// Module: button_debounce
//
// PURPOSE
// Input-side counterpart to the LED blinker: conditions a raw mechanical pushbutton into
// clean, clock-synchronous events. Synchronises the pin and filters contact bounce with a
// stability counter. Emits a debounced level plus single-cycle press/release strobes that
// downstream logic can consume (e.g. to toggle or reset an LED blinker).
//
// PARAMETERS
// DEBOUNCE_CYCLES  800000    cycles input must stay stable to be accepted (20 ms @ 40 MHz); >=2
// LONG_CYCLES      40000000  cycles held in PRESSED before long_press fires (1 s @ 40 MHz); >=2
// ACTIVE_LOW       1         1: pin reads 0 when pressed; 0: pin reads 1 when pressed
//
// PORTS
// clk          in   1  system clock, all logic on posedge
// rst          in   1  asynchronous, active-low reset (0 = reset asserted)
// btn_raw      in   1  raw button pin, asynchronous to clk, may bounce
// btn_level    out  1  debounced level, 1 = pressed
// press_pulse  out  1  one-cycle strobe on accepted press
// release_pulse out 1  one-cycle strobe on accepted release
// long_press   out  1  one-cycle strobe after LONG_CYCLES of continuous press
//
// BEHAVIOUR
// - Reset (rst=0, async): all outputs 0, state RELEASED, counters 0, sync FFs = "not pressed".
// - Sync: 2-FF synchroniser on btn_raw; polarity normalised after sync (pressed -> p=1).
// - Counter width $clog2(max(DEBOUNCE_CYCLES,LONG_CYCLES)); no wrap, compare-and-clear only.
// - FSM states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
//   RELEASED:     p=1 -> PRESS_WAIT, cnt<=0.
//   PRESS_WAIT:   p=0 -> RELEASED (bounce, no output); p=1 & cnt==DEBOUNCE_CYCLES-1 -> PRESSED;
//                 else cnt++.
//   PRESSED:      p=0 -> RELEASE_WAIT, cnt<=0; else stay.
//   RELEASE_WAIT: p=1 -> PRESSED (bounce, no output); p=0 & cnt==DEBOUNCE_CYCLES-1 -> RELEASED;
//                 else cnt++.
// - btn_level registered: 1 exactly while in PRESSED or RELEASE_WAIT.
// - press_pulse=1 for exactly the first cycle in PRESSED entered from PRESS_WAIT.
//   Re-entry from RELEASE_WAIT does not fire it. release_pulse mirrors this on entry to
//   RELEASED from RELEASE_WAIT.
// - Latency: clean edge on btn_raw -> btn_level/strobe change after DEBOUNCE_CYCLES+3 edges.
// - A bounce restarts the filter; the count does not accumulate across bounces.
// - press_pulse and release_pulse are never both 1 in the same cycle.
// - Reset mid-press: outputs drop to 0 immediately; no release_pulse is generated.
// - Held button stays PRESSED indefinitely; no repeated press_pulse.
//
// CONFIGURATION
// - Macro BUTTON_DEBOUNCE_LONG_PRESS_EN.
// - Defined: separate hold counter clears on every entry to PRESSED from PRESS_WAIT, then
//   counts while in PRESSED/RELEASE_WAIT.
//   - Fires long_press for one cycle when hold counter reaches LONG_CYCLES-1; then saturates.
//   - Fires at most once per accepted press; a bounce through RELEASE_WAIT does not restart it.
//   - Cleared on entry to RELEASED.
// - Undefined: hold counter not built; long_press tied to 0. Port list is unchanged.
//
// TESTING  (bench: DEBOUNCE_CYCLES=8, LONG_CYCLES=32, ACTIVE_LOW=1)
// - Reset: rst=0 with btn_raw=0 -> all outputs 0; release rst, btn_raw=1 held -> no strobes.
// - Clean press: btn_raw 1->0 held -> btn_level=1 and press_pulse=1 for 1 cycle at edge 11.
// - Bounce: btn_raw=0 for 5 cycles, 1 for 2, then 0 held -> no strobe during bounce;
//   press_pulse 11 edges after the final 1->0.
// - Release bounce: while pressed, toggle btn_raw 1/0 every 3 cycles x4, then 1 held ->
//   btn_level stays 1 throughout; single release_pulse 11 edges after the final 0->1.
// - Long press (macro on): hold pressed -> long_press exactly once, 32 edges after
//   press_pulse; holding 100 more cycles -> no second pulse. Macro off -> long_press=0.
// - Reset mid-press: rst=0 while btn_level=1 -> btn_level=0 asynchronously, no release_pulse;
//   after rst=1 with button still pressed -> new press_pulse at edge 11.

Source files
------------

// File: rtl/button_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, stability-count debounce FSM, press/release strobes.
// Optional hold detector (long_press) is built when BUTTON_DEBOUNCE_LONG_PRESS_EN is defined.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 800000,
  parameter int LONG_CYCLES     = 40000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  // Pin level that means "not pressed"; the synchroniser resets to it.
  localparam logic IDLE_LEVEL = ACTIVE_LOW;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    sync_q;
  logic          p;
  logic          press_accept;
  logic          release_accept;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {2{IDLE_LEVEL}};
    end else begin
      sync_q <= {sync_q[0], btn_raw};
    end
  end

  assign p              = sync_q[1] ^ ACTIVE_LOW;
  assign press_accept   = (state == PRESS_WAIT) && p && (cnt == DB_LAST);
  assign release_accept = (state == RELEASE_WAIT) && !p && (cnt == DB_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= RELEASED;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        RELEASED: begin
          if (p) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!p) begin
            state <= RELEASED;
          end else if (press_accept) begin
            state       <= PRESSED;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!p) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          // Bounce back to PRESSED is silent: level never dropped.
          if (p) begin
            state <= PRESSED;
          end else if (release_accept) begin
            state         <= RELEASED;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RELEASED;
      endcase
    end
  end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

  logic [CW-1:0] hold_cnt;
  logic          hold_done;

  // Hold time runs across release bounces; only an accepted press or release restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt   <= '0;
      hold_done  <= 1'b0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (press_accept || release_accept) begin
        hold_cnt  <= '0;
        hold_done <= 1'b0;
      end else if ((state == PRESSED || state == RELEASE_WAIT) && !hold_done) begin
        if (hold_cnt == LONG_LAST) begin
          long_press <= 1'b1;
          hold_done  <= 1'b1;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: segment table drives btn_raw, a queue
// scoreboard holds the expected {btn_level, press, release, long} for every clock edge.
module tb_button_debounce;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_raw = 1'b0;
  logic btn_level, press_pulse, release_pulse, long_press;

  button_debounce #(
    .DEBOUNCE_CYCLES(8),
    .LONG_CYCLES    (32),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_press   (long_press)
  );

  always #5 clk = ~clk;

  // One segment: btn_raw held for 'cycles' edges; *_at = edge (1-based) of the strobe, -1 = none.
  typedef struct {
    logic  btn;
    int    cycles;
    int    press_at;
    int    release_at;
    int    long_at;
    string tag;
  } seg_t;

  typedef struct {
    logic [3:0] vec;
    string      tag;
  } exp_t;

  exp_t  sb_q[$];
  seg_t  segs[$];
  int    checks = 0;
  int    errors = 0;
  logic  exp_level = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (lvl,press,rel,long)", name, act, req);
    end
  endtask

  // Scoreboard consumer: compares outputs 1 time unit after each active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.tag, {28'd0, btn_level, press_pulse, release_pulse, long_press}, {28'd0, e.vec});
      end
    end
  end

  task automatic push_edge(input logic btn, input logic [3:0] vec, input string tag);
    exp_t e;
    @(negedge clk);
    btn_raw = btn;
    e.vec = vec;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic apply_seg(input seg_t s);
    logic pr, rl, lg;
    for (int i = 1; i <= s.cycles; i++) begin
      pr = (i == s.press_at);
      rl = (i == s.release_at);
      lg = (i == s.long_at);
      if (pr) exp_level = 1'b1;
      if (rl) exp_level = 1'b0;
      push_edge(s.btn, {exp_level, pr, rl, lg}, s.tag);
      rst = 1'b1;
    end
  endtask

  task automatic run_table();
    for (int k = 0; k < segs.size(); k++) apply_seg(segs[k]);
    segs.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    // Reset held with the pin reading "pressed": nothing may come out.
    #1;
    check("reset_async", {28'd0, btn_level, press_pulse, release_pulse, long_press}, 32'd0);
    for (int i = 0; i < 3; i++) push_edge(1'b0, 4'b0000, "reset_hold");

    segs.push_back('{1'b1, 20, -1, -1, -1, "idle_after_reset"});
    segs.push_back('{1'b0, 20, 11, -1, -1, "clean_press"});
    segs.push_back('{1'b1, 20, -1, 11, -1, "clean_release"});
    segs.push_back('{1'b0,  5, -1, -1, -1, "press_bounce_lo"});
    segs.push_back('{1'b1,  2, -1, -1, -1, "press_bounce_hi"});
    segs.push_back('{1'b0, 15, 11, -1, -1, "press_after_bounce"});
    segs.push_back('{1'b1, 15, -1, 11, -1, "release_after_bounce_press"});
    segs.push_back('{1'b0, 12, 11, -1, -1, "press_before_rel_bounce"});
    for (int i = 0; i < 4; i++) begin
      segs.push_back('{1'b1, 3, -1, -1, -1, "rel_bounce_hi"});
      segs.push_back('{1'b0, 3, -1, -1, -1, "rel_bounce_lo"});
    end
    // Hold time keeps running through the release bounce, so long_press lands here.
    segs.push_back('{1'b1, 15, -1, 11, LONG_EN ? 7 : -1, "release_after_bounce"});
    segs.push_back('{1'b0, 143, 11, -1, LONG_EN ? 43 : -1, "long_hold"});
    segs.push_back('{1'b1, 15, -1, 11, -1, "release_after_long"});
    segs.push_back('{1'b0, 15, 11, -1, -1, "press_before_reset"});
    run_table();

    // Reset mid-press: level drops without waiting for a clock, no release strobe.
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("reset_mid_press_async", {28'd0, btn_level, press_pulse, release_pulse, long_press}, 32'd0);
    exp_level = 1'b0;
    for (int i = 0; i < 3; i++) push_edge(1'b0, 4'b0000, "reset_mid_press_hold");

    segs.push_back('{1'b0, 15, 11, -1, -1, "press_after_reset"});
    segs.push_back('{1'b1, 15, -1, 11, -1, "final_release"});
    run_table();

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drain", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
